// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the memory-stage/DMA requesters, the data-memory arbiter
// and the single-port synchronous-read data memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters plus memory environment
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer sharing the single-port data memory between the CPU
// memory stage and a DMA/debug port; covers the one-cycle read latency.
module dmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RR_EN  = 1
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_DMA = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } grant_t;

    state_t            state;
    state_t            stateNext;
    grant_t            lastGrant;
    grant_t            lastGrantNext;
    logic [DATA_W-1:0] cpuRdataQ;

    logic              cpuWins;
    logic              dmaWins;

    logic [ADDR_W-1:0] memAddrMux;
    logic              memWeMux;
    logic [DATA_W-1:0] memWdataMux;
    logic              cpuStall;
    logic              dmaGnt;
    logic              dmaRvalid;
    logic [DATA_W-1:0] dmaRdata;
    logic [DATA_W-1:0] cpuRdata;

    // Arbitration only happens in IDLE; round-robin favours the side not served last
    always_comb begin
        cpuWins = 1'b0;
        dmaWins = 1'b0;
        if (state == IDLE) begin
            if (bus.cpu_req && bus.dma_req) begin
                if ((RR_EN != 0) && (lastGrant == GNT_CPU)) begin
                    dmaWins = 1'b1;
                end else begin
                    cpuWins = 1'b1;
                end
            end else if (bus.cpu_req) begin
                cpuWins = 1'b1;
            end else if (bus.dma_req) begin
                dmaWins = 1'b1;
            end
        end
    end

    always_comb begin
        stateNext     = state;
        lastGrantNext = lastGrant;
        memAddrMux    = '0;
        memWeMux      = 1'b0;
        memWdataMux   = '0;
        cpuStall      = 1'b0;
        dmaGnt        = 1'b0;
        dmaRvalid     = 1'b0;
        dmaRdata      = '0;
        cpuRdata      = cpuRdataQ;

        unique case (state)
            IDLE: begin
                if (cpuWins) begin
                    memAddrMux    = bus.cpu_addr;
                    memWeMux      = bus.cpu_we;
                    memWdataMux   = bus.cpu_wdata;
                    lastGrantNext = GNT_CPU;
                    if (!bus.cpu_we) begin
                        cpuStall  = 1'b1;
                        stateNext = RD_CPU;
                    end
                end else if (dmaWins) begin
                    memAddrMux    = bus.dma_addr;
                    memWeMux      = bus.dma_we;
                    memWdataMux   = bus.dma_wdata;
                    lastGrantNext = GNT_DMA;
                    dmaGnt        = 1'b1;
                    cpuStall      = bus.cpu_req;
                    if (!bus.dma_we) begin
                        stateNext = RD_DMA;
                    end
                end
            end
            RD_CPU: begin
                // Data cycle: the still-held CPU request is the one being answered
                cpuRdata  = bus.mem_rdata;
                stateNext = IDLE;
            end
            RD_DMA: begin
                dmaRvalid = 1'b1;
                dmaRdata  = bus.mem_rdata;
                cpuStall  = bus.cpu_req;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lastGrant <= GNT_DMA;
            cpuRdataQ <= '0;
        end else begin
            state     <= stateNext;
            lastGrant <= lastGrantNext;
            if (state == RD_CPU) begin
                cpuRdataQ <= bus.mem_rdata;
            end
        end
    end

    // Outputs are forced low while reset is held, even with requests pending
    assign bus.mem_addr   = reset ? memAddrMux  : '0;
    assign bus.mem_we     = reset ? memWeMux    : 1'b0;
    assign bus.mem_wdata  = reset ? memWdataMux : '0;
    assign bus.cpu_stall  = reset ? cpuStall    : 1'b0;
    assign bus.cpu_rdata  = reset ? cpuRdata    : '0;
    assign bus.dma_gnt    = reset ? dmaGnt      : 1'b0;
    assign bus.dma_rvalid = reset ? dmaRvalid   : 1'b0;
    assign bus.dma_rdata  = reset ? dmaRdata    : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin and a fixed-priority instance
// share one stimulus, each backed by its own synchronous-read memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cpuReq = 1'b0;
    logic        cpuWe = 1'b0;
    logic [15:0] cpuAddr = '0;
    logic [15:0] cpuWdata = '0;
    logic        dmaReq = 1'b0;
    logic        dmaWe = 1'b0;
    logic [15:0] dmaAddr = '0;
    logic [15:0] dmaWdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifA ();
    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifB ();

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .RR_EN(1)) dutRr (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifA.slave)
    );

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .RR_EN(0)) dutFix (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifB.slave)
    );

    assign ifA.cpu_req   = cpuReq;
    assign ifA.cpu_we    = cpuWe;
    assign ifA.cpu_addr  = cpuAddr;
    assign ifA.cpu_wdata = cpuWdata;
    assign ifA.dma_req   = dmaReq;
    assign ifA.dma_we    = dmaWe;
    assign ifA.dma_addr  = dmaAddr;
    assign ifA.dma_wdata = dmaWdata;
    assign ifB.cpu_req   = cpuReq;
    assign ifB.cpu_we    = cpuWe;
    assign ifB.cpu_addr  = cpuAddr;
    assign ifB.cpu_wdata = cpuWdata;
    assign ifB.dma_req   = dmaReq;
    assign ifB.dma_we    = dmaWe;
    assign ifB.dma_addr  = dmaAddr;
    assign ifB.dma_wdata = dmaWdata;

    // Synchronous-read single-port memories
    logic [15:0] memA [0:65535];
    logic [15:0] memB [0:65535];
    logic [15:0] rdA = '0;
    logic [15:0] rdB = '0;

    always @(posedge clk) begin
        if (ifA.mem_we) memA[ifA.mem_addr] <= ifA.mem_wdata;
        rdA <= memA[ifA.mem_addr];
        if (ifB.mem_we) memB[ifB.mem_addr] <= ifB.mem_wdata;
        rdB <= memB[ifB.mem_addr];
    end

    assign ifA.mem_rdata = rdA;
    assign ifB.mem_rdata = rdB;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
        dmaReq = 1'b0; dmaWe = 1'b0; dmaAddr = '0; dmaWdata = '0;
    endtask

    task automatic pulseReset();
        idleInputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 16'h0055; cpuWdata = 16'h1111;
        dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 16'h0066;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifA.cpu_stall, ifA.dma_gnt, ifA.dma_rvalid, ifA.mem_we, ifA.mem_addr,
             ifA.mem_wdata, ifA.cpu_rdata, ifA.dma_rdata} !== 68'h0) begin
            errors++;
            $display("FAIL reset_outputs_rr: got %h, want all zero",
                     {ifA.cpu_stall, ifA.dma_gnt, ifA.dma_rvalid, ifA.mem_we, ifA.mem_addr,
                      ifA.mem_wdata, ifA.cpu_rdata, ifA.dma_rdata});
        end
        checks++;
        if ({ifB.cpu_stall, ifB.dma_gnt, ifB.dma_rvalid, ifB.mem_we, ifB.mem_addr,
             ifB.mem_wdata, ifB.cpu_rdata, ifB.dma_rdata} !== 68'h0) begin
            errors++;
            $display("FAIL reset_outputs_fix: got %h, want all zero",
                     {ifB.cpu_stall, ifB.dma_gnt, ifB.dma_rvalid, ifB.mem_we, ifB.mem_addr,
                      ifB.mem_wdata, ifB.cpu_rdata, ifB.dma_rdata});
        end
        idleInputs();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_cpu_write_read();
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 16'h0010; cpuWdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({ifA.mem_we, ifA.mem_addr, ifA.mem_wdata, ifA.cpu_stall, ifA.dma_gnt} !== {1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL cpu_write: got we/addr/wdata/stall/gnt=%h, want %h",
                     {ifA.mem_we, ifA.mem_addr, ifA.mem_wdata, ifA.cpu_stall, ifA.dma_gnt},
                     {1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0});
        end
        step();
        cpuWe = 1'b0; cpuWdata = '0;
        @(negedge clk);
        checks++;
        if ({ifA.mem_we, ifA.mem_addr, ifA.cpu_stall} !== {1'b0, 16'h0010, 1'b1}) begin
            errors++;
            $display("FAIL cpu_read_issue: got we/addr/stall=%h, want %h",
                     {ifA.mem_we, ifA.mem_addr, ifA.cpu_stall}, {1'b0, 16'h0010, 1'b1});
        end
        step();
        @(negedge clk);
        checks++;
        if ({ifA.cpu_stall, ifA.cpu_rdata, ifA.mem_we, ifA.mem_addr, ifA.dma_gnt} !== {1'b0, 16'hBEEF, 1'b0, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL cpu_read_data: got stall/rdata/we/addr/gnt=%h, want %h",
                     {ifA.cpu_stall, ifA.cpu_rdata, ifA.mem_we, ifA.mem_addr, ifA.dma_gnt},
                     {1'b0, 16'hBEEF, 1'b0, 16'h0000, 1'b0});
        end
        step();
        idleInputs();
        @(negedge clk);
        checks++;
        if ({ifA.cpu_rdata, ifA.cpu_stall} !== {16'hBEEF, 1'b0}) begin
            errors++;
            $display("FAIL cpu_rdata_hold: got rdata/stall=%h, want %h",
                     {ifA.cpu_rdata, ifA.cpu_stall}, {16'hBEEF, 1'b0});
        end
        step();
    endtask

    task automatic test_dma_read();
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 16'h0020; cpuWdata = 16'h1234;
        step();
        idleInputs();
        dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 16'h0020;
        @(negedge clk);
        checks++;
        if ({ifA.dma_gnt, ifA.dma_rvalid, ifA.mem_we, ifA.mem_addr, ifA.cpu_stall} !== {1'b1, 1'b0, 1'b0, 16'h0020, 1'b0}) begin
            errors++;
            $display("FAIL dma_read_gnt: got gnt/rvalid/we/addr/stall=%h, want %h",
                     {ifA.dma_gnt, ifA.dma_rvalid, ifA.mem_we, ifA.mem_addr, ifA.cpu_stall},
                     {1'b1, 1'b0, 1'b0, 16'h0020, 1'b0});
        end
        step();
        idleInputs();
        @(negedge clk);
        checks++;
        if ({ifA.dma_rvalid, ifA.dma_rdata, ifA.dma_gnt, ifA.mem_we} !== {1'b1, 16'h1234, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL dma_read_data: got rvalid/rdata/gnt/we=%h, want %h",
                     {ifA.dma_rvalid, ifA.dma_rdata, ifA.dma_gnt, ifA.mem_we},
                     {1'b1, 16'h1234, 1'b0, 1'b0});
        end
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ifA.dma_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL dma_rvalid_extra[%0d]: got %b, want 0", k, ifA.dma_rvalid);
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        pulseReset();
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 16'h0100; cpuWdata = 16'hAAAA;
        dmaReq = 1'b1; dmaWe = 1'b1; dmaAddr = 16'h0200; dmaWdata = 16'h5555;
        for (int k = 0; k < 4; k++) begin
            logic [17:0] want;
            want = (k % 2 == 1) ? {1'b1, 1'b1, 16'h0200} : {1'b0, 1'b0, 16'h0100};
            @(negedge clk);
            checks++;
            if ({ifA.dma_gnt, ifA.cpu_stall, ifA.mem_addr} !== want) begin
                errors++;
                $display("FAIL rr_alternate[%0d]: got gnt/stall/addr=%h, want %h",
                         k, {ifA.dma_gnt, ifA.cpu_stall, ifA.mem_addr}, want);
            end
            step();
        end
        idleInputs();
        step();
    endtask

    task automatic test_fixed_priority();
        pulseReset();
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 16'h0100; cpuWdata = 16'hAAAA;
        dmaReq = 1'b1; dmaWe = 1'b1; dmaAddr = 16'h0200; dmaWdata = 16'h5555;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({ifB.dma_gnt, ifB.cpu_stall, ifB.mem_we, ifB.mem_addr} !== {1'b0, 1'b0, 1'b1, 16'h0100}) begin
                errors++;
                $display("FAIL fixed_cpu_wins[%0d]: got gnt/stall/we/addr=%h, want %h",
                         k, {ifB.dma_gnt, ifB.cpu_stall, ifB.mem_we, ifB.mem_addr},
                         {1'b0, 1'b0, 1'b1, 16'h0100});
            end
            step();
        end
        cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
        @(negedge clk);
        checks++;
        if ({ifB.dma_gnt, ifB.mem_we, ifB.mem_addr, ifB.mem_wdata} !== {1'b1, 1'b1, 16'h0200, 16'h5555}) begin
            errors++;
            $display("FAIL fixed_dma_after_cpu: got gnt/we/addr/wdata=%h, want %h",
                     {ifB.dma_gnt, ifB.mem_we, ifB.mem_addr, ifB.mem_wdata},
                     {1'b1, 1'b1, 16'h0200, 16'h5555});
        end
        step();
        idleInputs();
        step();
    endtask

    task automatic test_back_to_back_reads();
        // Preload: DMA write then CPU write, leaving the CPU as last grant
        dmaReq = 1'b1; dmaWe = 1'b1; dmaAddr = 16'h0040; dmaWdata = 16'h4444;
        step();
        idleInputs();
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 16'h0030; cpuWdata = 16'h7777;
        step();
        cpuWe = 1'b0; cpuWdata = '0;
        dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 16'h0040;
        @(negedge clk);
        checks++;
        if ({ifA.dma_gnt, ifA.cpu_stall, ifA.mem_addr} !== {1'b1, 1'b1, 16'h0040}) begin
            errors++;
            $display("FAIL pend_dma_gnt: got gnt/stall/addr=%h, want %h",
                     {ifA.dma_gnt, ifA.cpu_stall, ifA.mem_addr}, {1'b1, 1'b1, 16'h0040});
        end
        step();
        dmaReq = 1'b0; dmaAddr = '0;
        @(negedge clk);
        checks++;
        if ({ifA.dma_rvalid, ifA.dma_rdata, ifA.cpu_stall, ifA.dma_gnt} !== {1'b1, 16'h4444, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL pend_rd_dma: got rvalid/rdata/stall/gnt=%h, want %h",
                     {ifA.dma_rvalid, ifA.dma_rdata, ifA.cpu_stall, ifA.dma_gnt},
                     {1'b1, 16'h4444, 1'b1, 1'b0});
        end
        step();
        @(negedge clk);
        checks++;
        if ({ifA.cpu_stall, ifA.mem_we, ifA.mem_addr, ifA.dma_rvalid} !== {1'b1, 1'b0, 16'h0030, 1'b0}) begin
            errors++;
            $display("FAIL pend_cpu_issue: got stall/we/addr/rvalid=%h, want %h",
                     {ifA.cpu_stall, ifA.mem_we, ifA.mem_addr, ifA.dma_rvalid},
                     {1'b1, 1'b0, 16'h0030, 1'b0});
        end
        step();
        @(negedge clk);
        checks++;
        if ({ifA.cpu_stall, ifA.cpu_rdata, ifA.dma_gnt} !== {1'b0, 16'h7777, 1'b0}) begin
            errors++;
            $display("FAIL pend_cpu_data: got stall/rdata/gnt=%h, want %h",
                     {ifA.cpu_stall, ifA.cpu_rdata, ifA.dma_gnt}, {1'b0, 16'h7777, 1'b0});
        end
        step();
        idleInputs();
        step();
    endtask

    task automatic test_reset_mid_read();
        dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 16'h0040;
        @(negedge clk);
        checks++;
        if (ifA.dma_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_gnt: got %b, want 1", ifA.dma_gnt);
        end
        step();
        idleInputs();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifA.dma_rvalid, ifA.dma_rdata, ifA.cpu_stall, ifA.dma_gnt, ifA.mem_we,
             ifA.mem_addr, ifA.mem_wdata, ifA.cpu_rdata} !== 68'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h, want all zero",
                     {ifA.dma_rvalid, ifA.dma_rdata, ifA.cpu_stall, ifA.dma_gnt, ifA.mem_we,
                      ifA.mem_addr, ifA.mem_wdata, ifA.cpu_rdata});
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ifA.dma_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_rvalid: got %b, want 0", ifA.dma_rvalid);
        end
        step();
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 16'h0300; cpuWdata = 16'h0F0F;
        dmaReq = 1'b1; dmaWe = 1'b1; dmaAddr = 16'h0400; dmaWdata = 16'hF0F0;
        @(negedge clk);
        checks++;
        if ({ifA.dma_gnt, ifA.cpu_stall, ifA.mem_addr, ifA.dma_rvalid} !== {1'b0, 1'b0, 16'h0300, 1'b0}) begin
            errors++;
            $display("FAIL midrst_cpu_first: got gnt/stall/addr/rvalid=%h, want %h",
                     {ifA.dma_gnt, ifA.cpu_stall, ifA.mem_addr, ifA.dma_rvalid},
                     {1'b0, 1'b0, 16'h0300, 1'b0});
        end
        step();
        idleInputs();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idleInputs();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_cpu_write_read();
        test_dma_read();
        test_round_robin();
        test_fixed_priority();
        test_back_to_back_reads();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
